// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, data-memory load/store over a ready handshake, MEM/WB register.
// Non-memory and zero-wait ops reach MEM/WB one edge after capture; mem_stall holds the front of the pipe while dmem waits.
module mem_stage #(
  parameter int WAIT_LIMIT    = 64,
  parameter int WAITCNT_WIDTH = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_result_2,
  input  logic        ex_load_inst,
  input  logic        ex_store_inst,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic [4:0]  ex_dest_reg,
  input  logic        ex_dest_reg_valid,
  input  logic        ex_inval_dest_reg,
  input  logic        ex_stall,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  ex_mem_dest_reg,
  output logic        ex_mem_dest_reg_valid,
  output logic [31:0] result_from_ex_mem,
  output logic [4:0]  mem_wb_dest_reg,
  output logic        mem_wb_dest_reg_valid,
  output logic [31:0] result_from_mem_wb,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                   state, state_nxt;
  logic [WAITCNT_WIDTH-1:0] wait_cnt, wait_cnt_nxt;

  logic        exm_valid, exm_load, exm_store, exm_unsigned;
  logic        exm_dest_valid, exm_inval;
  logic [1:0]  exm_size;
  logic [4:0]  exm_dest;
  logic [31:0] exm_result, exm_data;

  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_result;

  logic        misaligned, mem_op, mem_go, timeout, retire, capture;
  logic [3:0]  store_be;
  logic [15:0] lane;
  logic [31:0] load_val;

  assign misaligned = (exm_size == 2'd1) ? exm_result[0] :
                      (exm_size[1]       ? |exm_result[1:0] : 1'b0);
  assign mem_op    = exm_valid & (exm_load | exm_store);
  assign mem_go    = mem_op & ~misaligned;
  assign timeout   = (state == S_WAIT) & ~dmem_ready &
                     (wait_cnt == WAITCNT_WIDTH'(WAIT_LIMIT));
  assign mem_stall = mem_go & ~dmem_ready & ~timeout;
  assign retire    = exm_valid & ~mem_stall;
  assign capture   = ex_valid & ~ex_stall & ~mem_stall;

  assign addr_err = mem_op & misaligned;
  assign bus_err  = timeout;

  // Request is driven straight from EX/MEM, so addr/wdata/be stay stable across waits.
  assign dmem_rd   = mem_go & exm_load;
  assign dmem_wr   = mem_go & exm_store;
  assign dmem_addr = {exm_result[31:2], 2'b00};
  assign dmem_be   = mem_go ? (exm_load ? 4'b1111 : store_be) : 4'b0000;

  always_comb begin
    store_be   = 4'b1111;
    dmem_wdata = exm_data;
    case (exm_size)
      2'd0: begin
        store_be   = 4'b0001 << exm_result[1:0];
        dmem_wdata = {4{exm_data[7:0]}};
      end
      2'd1: begin
        store_be   = exm_result[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{exm_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Little-endian lane select, then extend.
  assign lane = 16'(dmem_rdata >> {exm_result[1:0], 3'b000});

  always_comb begin
    load_val = dmem_rdata;
    case (exm_size)
      2'd0:    load_val = exm_unsigned ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_val = exm_unsigned ? {16'b0, lane} : {{16{lane[15]}}, lane};
      default: ;
    endcase
  end

  assign ex_mem_dest_reg       = exm_dest;
  assign ex_mem_dest_reg_valid = exm_valid & exm_dest_valid & ~exm_inval & ~exm_load;
  assign result_from_ex_mem    = exm_result;
  assign mem_wb_dest_reg       = wb_dest;
  assign mem_wb_dest_reg_valid = wb_valid;
  assign result_from_mem_wb    = wb_result;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (mem_go && !dmem_ready) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = WAITCNT_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ready || timeout) state_nxt = S_IDLE;
        else                       wait_cnt_nxt = wait_cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // A retired op is dropped from EX/MEM so a later ex_stall cannot replay it.
  always_ff @(posedge clock) begin
    if (reset) begin
      exm_valid      <= 1'b0;
      exm_load       <= 1'b0;
      exm_store      <= 1'b0;
      exm_unsigned   <= 1'b0;
      exm_dest_valid <= 1'b0;
      exm_inval      <= 1'b0;
      exm_size       <= 2'd0;
      exm_dest       <= 5'd0;
      exm_result     <= 32'd0;
      exm_data       <= 32'd0;
    end else if (capture) begin
      exm_valid      <= 1'b1;
      exm_load       <= ex_load_inst;
      exm_store      <= ex_store_inst;
      exm_unsigned   <= ex_mem_unsigned;
      exm_dest_valid <= ex_dest_reg_valid;
      exm_inval      <= ex_inval_dest_reg;
      exm_size       <= ex_mem_size;
      exm_dest       <= ex_dest_reg;
      exm_result     <= ex_result;
      exm_data       <= ex_result_2;
    end else if (retire) begin
      exm_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_dest   <= 5'd0;
      wb_result <= 32'd0;
    end else begin
      wb_valid <= retire & exm_dest_valid & ~exm_inval & ~exm_store &
                  ~(mem_op & misaligned) & ~timeout;
      if (retire) begin
        wb_dest   <= exm_dest;
        wb_result <= (exm_load & ~misaligned & ~timeout) ? load_val : exm_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU forwarding, load extension, store lanes, waits, misalign, timeout, reset in WAIT.
module tb_mem_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load_inst, ex_store_inst, ex_mem_unsigned;
  logic        ex_dest_reg_valid, ex_inval_dest_reg, ex_stall;
  logic [31:0] ex_result, ex_result_2;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_dest_reg;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_rd, dmem_wr, dmem_ready, mem_stall;
  logic [4:0]  ex_mem_dest_reg, mem_wb_dest_reg;
  logic        ex_mem_dest_reg_valid, mem_wb_dest_reg_valid, addr_err, bus_err;
  logic [31:0] result_from_ex_mem, result_from_mem_wb;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  mem_stage #(.WAIT_LIMIT(64), .WAITCNT_WIDTH(7)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_result_2(ex_result_2),
    .ex_load_inst(ex_load_inst), .ex_store_inst(ex_store_inst),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_dest_reg(ex_dest_reg), .ex_dest_reg_valid(ex_dest_reg_valid),
    .ex_inval_dest_reg(ex_inval_dest_reg), .ex_stall(ex_stall),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .ex_mem_dest_reg(ex_mem_dest_reg), .ex_mem_dest_reg_valid(ex_mem_dest_reg_valid),
    .result_from_ex_mem(result_from_ex_mem),
    .mem_wb_dest_reg(mem_wb_dest_reg), .mem_wb_dest_reg_valid(mem_wb_dest_reg_valid),
    .result_from_mem_wb(result_from_mem_wb),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction for a single capture edge, then withdraw it.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] dest, input logic dv);
    ex_valid = 1'b1; ex_load_inst = ld; ex_store_inst = st; ex_mem_size = sz;
    ex_mem_unsigned = uns; ex_result = addr; ex_result_2 = data;
    ex_dest_reg = dest; ex_dest_reg_valid = dv; ex_inval_dest_reg = 1'b0;
    tick();
    ex_valid = 1'b0; ex_load_inst = 1'b0; ex_store_inst = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_load_inst = 1'b0; ex_store_inst = 1'b0;
    ex_mem_size = 2'd0; ex_mem_unsigned = 1'b0; ex_result = '0; ex_result_2 = '0;
    ex_dest_reg = '0; ex_dest_reg_valid = 1'b0; ex_inval_dest_reg = 1'b0;
    ex_stall = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_rd", dmem_rd, 0);
    check("rst_wr", dmem_wr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_exm_v", ex_mem_dest_reg_valid, 0);
    check("rst_wb_v", mem_wb_dest_reg_valid, 0);
    check("rst_wb_res", result_from_mem_wb, 0);
    reset = 1'b0;

    // ALU op forwarding then writeback
    issue(0, 0, 2'd2, 0, 32'h1234, 32'h0, 5'd5, 1);
    check("alu_exm_v", ex_mem_dest_reg_valid, 1);
    check("alu_exm_res", result_from_ex_mem, 32'h1234);
    check("alu_exm_dest", ex_mem_dest_reg, 5);
    tick();
    check("alu_wb_v", mem_wb_dest_reg_valid, 1);
    check("alu_wb_dest", mem_wb_dest_reg, 5);
    check("alu_wb_res", result_from_mem_wb, 32'h1234);
    check("alu_exm_clr", ex_mem_dest_reg_valid, 0);

    // lb / lbu at 0x103 with zero-wait ready
    for (int u = 0; u < 2; u++) begin
      issue(1, 0, 2'd0, u[0], 32'h103, 32'h0, 5'd6, 1);
      dmem_ready = 1'b1; dmem_rdata = 32'h80FF_0000;
      #1;
      check("lb_rd", dmem_rd, 1);
      check("lb_addr", dmem_addr, 32'h100);
      check("lb_be", dmem_be, 4'hF);
      check("lb_stall", mem_stall, 0);
      check("lb_nofwd", ex_mem_dest_reg_valid, 0);
      tick();
      dmem_ready = 1'b0;
      check("lb_wb_v", mem_wb_dest_reg_valid, 1);
      check("lb_wb_dest", mem_wb_dest_reg, 6);
      check(u ? "lbu_res" : "lb_res", result_from_mem_wb, u ? 32'h0000_0080 : 32'hFFFF_FF80);
    end

    // sh at 0x202
    issue(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 5'd9, 1);
    dmem_ready = 1'b1;
    #1;
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check("sh_wr", dmem_wr, 1);
    check("sh_rd", dmem_rd, 0);
    tick();
    dmem_ready = 1'b0;
    check("sh_wb_v", mem_wb_dest_reg_valid, 0);

    // lw with three wait cycles
    issue(1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd7, 1);
    dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      check("lw3_stall", mem_stall, 1);
      check("lw3_rd", dmem_rd, 1);
      check("lw3_addr", dmem_addr, 32'h300);
      check("lw3_be", dmem_be, 4'hF);
      tick();
      check("lw3_bubble", mem_wb_dest_reg_valid, 0);
    end
    dmem_ready = 1'b1;
    #1;
    check("lw3_done_stall", mem_stall, 0);
    tick();
    dmem_ready = 1'b0;
    check("lw3_wb_v", mem_wb_dest_reg_valid, 1);
    check("lw3_wb_res", result_from_mem_wb, 32'hDEAD_BEEF);
    check("lw3_wb_dest", mem_wb_dest_reg, 7);
    tick();
    check("lw3_once", mem_wb_dest_reg_valid, 0);

    // misaligned lw 0x101 and lh 0x103
    for (int k = 0; k < 2; k++) begin
      issue(1, 0, k ? 2'd1 : 2'd2, 0, k ? 32'h103 : 32'h101, 32'h0, 5'd8, 1);
      check("mis_err", addr_err, 1);
      check("mis_rd", dmem_rd, 0);
      check("mis_stall", mem_stall, 0);
      tick();
      check("mis_err_pulse", addr_err, 0);
      check("mis_wb_v", mem_wb_dest_reg_valid, 0);
    end

    // timeout: bus_err expected on the 65th request cycle
    issue(1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd10, 1);
    cyc = 0;
    while (cyc < 200 && !bus_err) begin
      tick();
      cyc++;
    end
    check("to_cycles", cyc, 64);
    check("to_stall", mem_stall, 0);
    tick();
    check("to_err_pulse", bus_err, 0);
    check("to_wb_v", mem_wb_dest_reg_valid, 0);
    check("to_rd_drop", dmem_rd, 0);
    issue(0, 0, 2'd2, 0, 32'h55, 32'h0, 5'd11, 1);
    tick();
    check("to_resume", result_from_mem_wb, 32'h55);

    // reset while in WAIT
    issue(1, 0, 2'd2, 0, 32'h500, 32'h0, 5'd12, 1);
    tick();
    check("rw_stall", mem_stall, 1);
    check("rw_rd", dmem_rd, 1);
    reset = 1'b1;
    tick();
    check("rw_rd0", dmem_rd, 0);
    check("rw_stall0", mem_stall, 0);
    check("rw_addr0", dmem_addr, 0);
    check("rw_wb_res0", result_from_mem_wb, 0);
    check("rw_exm_v0", ex_mem_dest_reg_valid, 0);
    reset = 1'b0;
    tick();
    check("rw_idle_rd", dmem_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and performs data-memory loads and stores over a ready-handshake bus.
- Aligns load data, generates store byte-enables, and produces the MEM/WB register.
- Supplies the forwarding sources (result_from_ex_mem, result_from_mem_wb and their dest-reg tags) back to execute. Stalls the front of the pipe while memory is busy.

Parameters:
- WAIT_LIMIT, 64, maximum wait cycles for dmem_ready before a bus error is flagged.
- WAITCNT_WIDTH, 7, width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction this cycle
- ex_result  in  32  ALU result or effective address
- ex_result_2  in  32  store data (forwarded B operand)
- ex_load_inst, ex_store_inst  in  1 each  memory op type
- ex_mem_size  in  2  0=byte, 1=half, 2=word
- ex_mem_unsigned  in  1  zero-extend load (lbu/lhu)
- ex_dest_reg  in  5  destination register
- ex_dest_reg_valid  in  1  destination register valid
- ex_inval_dest_reg  in  1  MOVZ/MOVN suppression
- ex_stall  in  1  execute stage stalled; do not capture
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rd, dmem_wr  out  1 each  request strobes
- dmem_ready  in  1  request completes this cycle
- dmem_rdata  in  32  read data, valid with dmem_ready
- mem_stall  out  1  stage cannot accept new instruction
- ex_mem_dest_reg  out  5  forwarding tag, EX/MEM
- ex_mem_dest_reg_valid  out  1  forwarding tag valid, EX/MEM
- result_from_ex_mem  out  32  EX/MEM forwarding value
- mem_wb_dest_reg  out  5  writeback register
- mem_wb_dest_reg_valid  out  1  writeback enable
- result_from_mem_wb  out  32  writeback/forwarding value
- addr_err  out  1  one-cycle pulse: misaligned access
- bus_err  out  1  one-cycle pulse: wait timeout

Behaviour:
- Reset (synchronous, active-high):
  - All registered state cleared; FSM to IDLE; EX/MEM and MEM/WB valid = 0.
  - Every output is 0 except dmem_addr, dmem_wdata and forwarding data, which are also 0.
- EX/MEM capture: on posedge when ex_valid & ~ex_stall & ~mem_stall; otherwise hold.
- Forwarding tag: ex_mem_dest_reg_valid = exm_valid & dest_valid & ~inval & ~load. Loads are never forwarded from EX/MEM; load-use is interlocked in decode.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - No dmem request is issued.
  - addr_err pulses one cycle.
  - Instruction retires to MEM/WB with dest valid = 0.
- Store byte-enables:
  - byte: be = 1<<addr[1:0]; wdata = {4{d[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{d[15:0]}}.
  - word: be = 4'b1111.
- Loads: dmem_be = 4'b1111. Select lane by addr[1:0] (little-endian), then sign- or zero-extend per ex_mem_unsigned.
- FSM states IDLE, WAIT:
  - IDLE: if EX/MEM holds a valid, aligned memory op, assert dmem_rd/dmem_wr combinationally.
    - dmem_ready=1: complete this cycle (zero-wait); stay IDLE.
    - Else: go to WAIT; wait counter = 1.
  - WAIT: request stays asserted with stable addr/wdata/be.
    - dmem_ready=1: complete; go to IDLE.
    - Else if counter == WAIT_LIMIT: pulse bus_err, retire with dest valid = 0, go to IDLE.
    - Else: counter increments.
- mem_stall = valid mem op in EX/MEM & ~dmem_ready (IDLE or WAIT), excluding the timeout cycle.
- MEM/WB register:
  - Loaded every cycle.
  - When EX/MEM completes: takes value (aligned load data or ex_result), dest reg, and dest valid & ~inval.
  - While mem_stall: a bubble (valid = 0) is inserted, so writeback never occurs twice.
- Latency: non-memory op, or zero-wait memory op, reaches MEM/WB one edge after EX/MEM capture. Each wait cycle adds one.
- Stores retire with mem_wb_dest_reg_valid = 0.
- Reset during WAIT: request strobes drop the cycle after the reset edge. The in-flight op is abandoned.

Test Plan:
- ALU op, ex_result=0x1234, dest=5 -> next cycle ex_mem_dest_reg_valid=1, result_from_ex_mem=0x1234; following cycle mem_wb_dest_reg=5, result_from_mem_wb=0x1234.
- lb at addr 0x103, rdata=0x80FF_0000, ready same cycle -> result 0xFFFF_FF80, mem_stall never high. lbu, same stimulus -> 0x0000_0080.
- sh at 0x202, data 0xABCD -> dmem_addr=0x200, be=4'b1100, wdata=0xABCD_ABCD, dmem_wr=1, no writeback.
- lw with 3 wait cycles -> mem_stall high 3 cycles, strobes and addr stable, exactly one MEM/WB write, bubbles in between.
- lw at 0x101 -> addr_err pulse, no dmem_rd, mem_wb_dest_reg_valid=0. lh at 0x103 -> same response.
- dmem_ready held low -> bus_err after WAIT_LIMIT cycles, pipe resumes. Separately, reset asserted in WAIT -> all outputs 0 next cycle, FSM IDLE.
